// File: rtl/seq_alu.sv
// Handshaked execute-stage ALU: single-cycle logic/arith/shift ops plus an
// iterative shift-add multiplier that holds ready_o low while it runs.
module seq_alu #(
  parameter int WIDTH    = 32,
  parameter int MUL_STEP = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  input  logic [3:0]       ALUCtrl_i,
  input  logic             abort_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic             zero_o,
  output logic             illegal_o
);

  localparam int MUL_ITER = WIDTH / MUL_STEP;
  localparam int SHW      = $clog2(WIDTH);
  localparam int CNT_W    = (MUL_ITER > 1) ? $clog2(MUL_ITER) : 1;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_XOR  = 4'b0001;
  localparam logic [3:0] OP_SLL  = 4'b0010;
  localparam logic [3:0] OP_ADD  = 4'b0011;
  localparam logic [3:0] OP_SUB  = 4'b0100;
  localparam logic [3:0] OP_MUL  = 4'b0101;
  localparam logic [3:0] OP_ADDI = 4'b0110;
  localparam logic [3:0] OP_SRAI = 4'b0111;
  localparam logic [3:0] OP_LW   = 4'b1000;
  localparam logic [3:0] OP_SW   = 4'b1001;
  localparam logic [3:0] OP_BEQ  = 4'b1010;

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t                    state;
  logic                      ready_q;
  logic                      valid_q;
  logic                      illegal_q;
  logic [WIDTH-1:0]          data_q;
  logic                      zero_q;
  logic signed [WIDTH-1:0]   acc_p1;
  logic [WIDTH-1:0]          mcand_p1;
  logic [WIDTH-1:0]          mplier_p1;
  logic [CNT_W-1:0]          cnt;

  logic [WIDTH-1:0]          alu_res;
  logic signed [WIDTH-1:0]   acc_sum;

  function automatic logic [WIDTH-1:0] alu_result(input logic [3:0] op,
                                                  input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
    logic [SHW-1:0] sh;
    sh = b[SHW-1:0];
    case (op)
      OP_AND:                         alu_result = a & b;
      OP_XOR:                         alu_result = a ^ b;
      OP_SLL:                         alu_result = a << sh;
      OP_ADD, OP_ADDI, OP_LW, OP_SW:  alu_result = a + b;
      OP_SUB, OP_BEQ:                 alu_result = a - b;
      OP_SRAI:                        alu_result = $unsigned($signed(a) >>> sh);
      default:                        alu_result = '0;
    endcase
  endfunction

  function automatic logic is_illegal(input logic [3:0] op);
    is_illegal = (op > OP_BEQ);
  endfunction

  // Partial product of the multiplicand with the next MUL_STEP multiplier bits.
  function automatic logic signed [WIDTH-1:0] mul_partial(input logic [WIDTH-1:0] mc,
                                                          input logic [MUL_STEP-1:0] bits);
    logic [WIDTH-1:0] p;
    p = '0;
    for (int i = 0; i < MUL_STEP; i++) begin
      if (bits[i]) p = p + (mc << i);
    end
    mul_partial = $signed(p);
  endfunction

  assign alu_res = alu_result(ALUCtrl_i, data1_i, data2_i);
  assign acc_sum = acc_p1 + mul_partial(mcand_p1, mplier_p1[MUL_STEP-1:0]);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= S_IDLE;
      ready_q   <= 1'b1;
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
      data_q    <= '0;
      zero_q    <= 1'b1;
      acc_p1    <= '0;
      mcand_p1  <= '0;
      mplier_p1 <= '0;
      cnt       <= '0;
    end else begin
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (valid_i) begin
            if (ALUCtrl_i == OP_MUL) begin
              acc_p1    <= '0;
              mcand_p1  <= data1_i;
              mplier_p1 <= data2_i;
              cnt       <= CNT_W'(MUL_ITER - 1);
              state     <= S_MUL;
              ready_q   <= 1'b0;
            end else begin
              data_q    <= alu_res;
              zero_q    <= (alu_res == '0);
              valid_q   <= 1'b1;
              illegal_q <= is_illegal(ALUCtrl_i);
            end
          end
        end
        S_MUL: begin
          // Abort wins over completion; the previous result stays visible.
          if (abort_i) begin
            state   <= S_IDLE;
            ready_q <= 1'b1;
          end else begin
            acc_p1    <= acc_sum;
            mcand_p1  <= mcand_p1 << MUL_STEP;
            mplier_p1 <= mplier_p1 >> MUL_STEP;
            if (cnt == '0) begin
              data_q  <= $unsigned(acc_sum);
              zero_q  <= (acc_sum == '0);
              valid_q <= 1'b1;
              state   <= S_IDLE;
              ready_q <= 1'b1;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
        end
        default: begin
          state   <= S_IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign ready_o   = ready_q;
  assign valid_o   = valid_q;
  assign data_o    = data_q;
  assign zero_o    = zero_q;
  assign illegal_o = illegal_q;

endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu: two instances (MUL_STEP=1 and MUL_STEP=4) against an
// operation-level reference model, plus directed literal checks.
module tb_seq_alu;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]       vin = '0;
  logic [1:0]       abt = '0;
  logic [1:0][31:0] a   = '0;
  logic [1:0][31:0] b   = '0;
  logic [1:0][3:0]  op  = '0;

  logic [1:0]       rdy, vld, zro, ill;
  logic [1:0][31:0] dat;

  int cmp_cnt  = 0;
  int fail_cnt = 0;

  seq_alu #(.WIDTH(32), .MUL_STEP(1)) u1 (
    .clk_i(clk), .rst_i(rst), .valid_i(vin[0]), .ready_o(rdy[0]),
    .data1_i(a[0]), .data2_i(b[0]), .ALUCtrl_i(op[0]), .abort_i(abt[0]),
    .valid_o(vld[0]), .data_o(dat[0]), .zero_o(zro[0]), .illegal_o(ill[0])
  );

  seq_alu #(.WIDTH(32), .MUL_STEP(4)) u4 (
    .clk_i(clk), .rst_i(rst), .valid_i(vin[1]), .ready_o(rdy[1]),
    .data1_i(a[1]), .data2_i(b[1]), .ALUCtrl_i(op[1]), .abort_i(abt[1]),
    .valid_o(vld[1]), .data_o(dat[1]), .zero_o(zro[1]), .illegal_o(ill[1])
  );

  task automatic chk(input string name, input int k, input logic [31:0] act,
                     input logic [31:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      fail_cnt++;
      $display("FAIL %s[inst%0d] at %0t: got %h, expected %h", name, k, $time, act, exp);
    end
  endtask

  // Reference ALU result straight from the opcode table.
  function automatic logic [31:0] alu_ref(input logic [3:0] o, input logic [31:0] x,
                                          input logic [31:0] y);
    int s;
    s = int'(y % 32);
    case (o)
      4'd0:                   return x & y;
      4'd1:                   return x ^ y;
      4'd2:                   return x << s;
      4'd3, 4'd6, 4'd8, 4'd9: return x + y;
      4'd4, 4'd10:            return x - y;
      4'd7:                   return $unsigned($signed(x) >>> s);
      default:                return 32'd0;
    endcase
  endfunction

  // Model: remaining-cycle countdown per instance; product computed at accept.
  logic [1:0]       m_busy = '0;
  logic [1:0]       m_vld  = '0;
  logic [1:0]       m_ill  = '0;
  logic [1:0][31:0] m_data = '0;
  logic [1:0][31:0] m_pend = '0;
  int               m_cnt [2];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= '0;
      m_vld  <= '0;
      m_ill  <= '0;
      m_data <= '0;
      for (int k = 0; k < 2; k++) m_cnt[k] <= 0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        m_vld[k] <= 1'b0;
        m_ill[k] <= 1'b0;
        if (m_busy[k]) begin
          if (abt[k]) m_busy[k] <= 1'b0;
          else if (m_cnt[k] == 1) begin
            m_busy[k] <= 1'b0;
            m_vld[k]  <= 1'b1;
            m_data[k] <= m_pend[k];
          end else m_cnt[k] <= m_cnt[k] - 1;
        end else if (vin[k]) begin
          if (op[k] == 4'd5) begin
            m_busy[k] <= 1'b1;
            m_cnt[k]  <= (k == 0) ? 32 : 8;
            m_pend[k] <= a[k] * b[k];
          end else begin
            m_vld[k]  <= 1'b1;
            m_data[k] <= alu_ref(op[k], a[k], b[k]);
            m_ill[k]  <= (op[k] > 4'd10);
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 2; k++) begin
        chk("model_ready",   k, 32'(rdy[k]), 32'(!m_busy[k]));
        chk("model_valid",   k, 32'(vld[k]), 32'(m_vld[k]));
        chk("model_illegal", k, 32'(ill[k]), 32'(m_ill[k]));
        chk("model_data",    k, dat[k], m_data[k]);
        chk("model_zero",    k, 32'(zro[k]), 32'(m_data[k] == 32'd0));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int k, input logic [3:0] o, input logic [31:0] x,
                       input logic [31:0] y);
    vin[k] = 1'b1;
    op[k]  = o;
    a[k]   = x;
    b[k]   = y;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Make data non-zero, then reset mid-cycle and check async clear.
    issue(0, 4'd0, 32'hFF, 32'h0F);
    step();
    vin[0] = 1'b0;
    chk("and_pre_reset", 0, dat[0], 32'h0F);
    #3 rst = 1'b1;
    #1;
    chk("rst_data",  0, dat[0], 32'd0);
    chk("rst_zero",  0, 32'(zro[0]), 32'd1);
    chk("rst_valid", 0, 32'(vld[0]), 32'd0);
    chk("rst_ready", 0, 32'(rdy[0]), 32'd1);
    step();
    rst = 1'b0;
    step();

    // Back-to-back single-cycle ops.
    issue(0, 4'd3, 32'h7FFF_FFFF, 32'd1);
    step();
    chk("add_data",  0, dat[0], 32'h8000_0000);
    chk("add_valid", 0, 32'(vld[0]), 32'd1);
    chk("add_ready", 0, 32'(rdy[0]), 32'd1);
    issue(0, 4'd4, 32'd5, 32'd5);
    step();
    chk("sub_data",  0, dat[0], 32'd0);
    chk("sub_zero",  0, 32'(zro[0]), 32'd1);
    chk("sub_valid", 0, 32'(vld[0]), 32'd1);
    issue(0, 4'd7, 32'h8000_0000, 32'h21);
    step();
    chk("srai_data",  0, dat[0], 32'hC000_0000);
    chk("srai_valid", 0, 32'(vld[0]), 32'd1);
    chk("srai_ready", 0, 32'(rdy[0]), 32'd1);
    issue(0, 4'd2, 32'h1, 32'h24);
    step();
    vin[0] = 1'b0;
    chk("sll_data", 0, dat[0], 32'h10);
    step();
    chk("idle_valid", 0, 32'(vld[0]), 32'd0);

    // MUL STEP=1: -3*7 with an XOR request held throughout.
    issue(0, 4'd5, 32'hFFFF_FFFD, 32'd7);
    step();
    issue(0, 4'd1, 32'h1234_5678, 32'h0F0F_0F0F);
    for (int i = 1; i < 32; i++) begin
      step();
      chk("mul1_ready_low", 0, 32'(rdy[0]), 32'd0);
      chk("mul1_no_valid",  0, 32'(vld[0]), 32'd0);
    end
    step();
    chk("mul1_data",  0, dat[0], 32'hFFFF_FFEB);
    chk("mul1_valid", 0, 32'(vld[0]), 32'd1);
    chk("mul1_ready", 0, 32'(rdy[0]), 32'd1);
    step();
    vin[0] = 1'b0;
    chk("held_xor_data",  0, dat[0], 32'h1D3B_5977);
    chk("held_xor_valid", 0, 32'(vld[0]), 32'd1);

    // MUL STEP=4 on the second instance.
    issue(1, 4'd5, 32'hFFFF, 32'hFFFF);
    step();
    vin[1] = 1'b0;
    for (int i = 1; i < 8; i++) begin
      step();
      chk("mul4_ready_low", 1, 32'(rdy[1]), 32'd0);
      chk("mul4_no_valid",  1, 32'(vld[1]), 32'd0);
    end
    step();
    chk("mul4_data",  1, dat[1], 32'hFFFE_0001);
    chk("mul4_valid", 1, 32'(vld[1]), 32'd1);

    // Abort at the 5th MUL edge, then AND issued together with abort_i.
    issue(0, 4'd5, 32'd3, 32'd5);
    step();
    vin[0] = 1'b0;
    repeat (3) step();
    abt[0] = 1'b1;
    step();
    chk("abort_no_valid", 0, 32'(vld[0]), 32'd0);
    chk("abort_ready",    0, 32'(rdy[0]), 32'd1);
    chk("abort_data",     0, dat[0], 32'h1D3B_5977);
    issue(0, 4'd0, 32'hF0, 32'h3C);
    step();
    vin[0] = 1'b0;
    abt[0] = 1'b0;
    chk("and_data",  0, dat[0], 32'h30);
    chk("and_valid", 0, 32'(vld[0]), 32'd1);

    // Illegal opcode.
    issue(0, 4'b1100, 32'd5, 32'd6);
    step();
    vin[0] = 1'b0;
    chk("ill_data",    0, dat[0], 32'd0);
    chk("ill_zero",    0, 32'(zro[0]), 32'd1);
    chk("ill_flag",    0, 32'(ill[0]), 32'd1);
    chk("ill_valid",   0, 32'(vld[0]), 32'd1);
    step();
    chk("ill_cleared", 0, 32'(ill[0]), 32'd0);
    chk("ill_vld_off", 0, 32'(vld[0]), 32'd0);

    repeat (2) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
    $finish;
  end

endmodule
